// File: rtl/axis_downsizer_pkt.sv
// Wide-to-narrow AXI4-Stream converter: each input beat is emitted as up to RATIO
// narrow words. Word count and order are programmable, and TLAST is placed on the final word.
module axis_downsizer_pkt #(
  parameter int S_AXIS_TDATA_WIDTH = 128,
  parameter int M_AXIS_TDATA_WIDTH = 32
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [15:0]                   cfg_data,
  input  logic [S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  output logic [M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast
);

  localparam int RATIO      = S_AXIS_TDATA_WIDTH / M_AXIS_TDATA_WIDTH;
  localparam int CNTR_WIDTH = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CNTR_WIDTH-1:0] MAX_IDX = CNTR_WIDTH'(RATIO - 1);

  logic [CNTR_WIDTH-1:0]         cntr_q, cntr_d;
  logic [CNTR_WIDTH-1:0]         last_idx_q, last_idx_d;
  logic                          order_q, order_d;
  logic [M_AXIS_TDATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                          tvalid_q, tvalid_d;
  logic                          tlast_q, tlast_d;

  logic [CNTR_WIDTH-1:0]         cfg_idx_s;
  logic [CNTR_WIDTH-1:0]         clamp_idx_s;
  logic [CNTR_WIDTH-1:0]         last_idx_s;
  logic                          order_s;
  logic [CNTR_WIDTH-1:0]         lane_s;
  logic [M_AXIS_TDATA_WIDTH-1:0] word_s;
  logic                          is_last_s;
  logic                          load_en_s;
  logic                          cfg_unused_s;

  assign cfg_idx_s    = cfg_data[CNTR_WIDTH-1:0];
  assign cfg_unused_s = ^cfg_data[14:CNTR_WIDTH];

  // A power-of-two RATIO cannot be exceeded by the index field, so only other ratios clamp.
  if ((1 << CNTR_WIDTH) == RATIO) begin : g_no_clamp
    assign clamp_idx_s = cfg_idx_s;
  end else begin : g_clamp
    assign clamp_idx_s = (cfg_idx_s > MAX_IDX) ? MAX_IDX : cfg_idx_s;
  end

  // Beat parameters: taken live from cfg_data on the first word, then from the latched copy.
  always_comb begin
    if (cntr_q == '0) begin
      last_idx_s = clamp_idx_s;
      order_s    = cfg_data[15];
    end else begin
      last_idx_s = last_idx_q;
      order_s    = order_q;
    end
  end

  // Lane selection and handshake terms.
  always_comb begin
    lane_s        = order_s ? (MAX_IDX - cntr_q) : cntr_q;
    word_s        = s_axis_tdata[int'(lane_s)*M_AXIS_TDATA_WIDTH +: M_AXIS_TDATA_WIDTH];
    is_last_s     = (cntr_q == last_idx_s);
    load_en_s     = ~tvalid_q | m_axis_tready;
    s_axis_tready = is_last_s & load_en_s;
  end

  // Next-state: advance the word counter and refill the output register on each load.
  always_comb begin
    last_idx_d = last_idx_s;
    order_d    = order_s;
    if (s_axis_tvalid && load_en_s) begin
      cntr_d  = is_last_s ? '0 : cntr_q + CNTR_WIDTH'(1);
      tdata_d = word_s;
      tlast_d = is_last_s & s_axis_tlast;
    end else begin
      cntr_d  = cntr_q;
      tdata_d = tdata_q;
      tlast_d = tlast_q;
    end
    if (load_en_s) begin
      tvalid_d = s_axis_tvalid;
    end else begin
      tvalid_d = tvalid_q;
    end
  end

  // State and output registers; reset abandons any partially emitted beat.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cntr_q     <= '0;
      last_idx_q <= '0;
      order_q    <= 1'b0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
    end else begin
      cntr_q     <= cntr_d;
      last_idx_q <= last_idx_d;
      order_q    <= order_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;

endmodule

// File: tb/tb_axis_downsizer_pkt.sv
// Self-checking bench for axis_downsizer_pkt: directed scenarios plus randomized beats
// checked against a per-beat word-list reference model.
`timescale 1ns/1ps
module tb_axis_downsizer_pkt;

  localparam int S  = 128;
  localparam int M  = 32;
  localparam int R  = S / M;
  localparam int CW = 2;
  localparam logic [S-1:0] BEAT = 128'h44444444_33333333_22222222_11111111;

  logic          aclk = 1'b0;
  logic          areset;
  logic [15:0]   cfg_data;
  logic [S-1:0]  s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic [M-1:0]  m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;

  always #5 aclk = ~aclk;

  axis_downsizer_pkt #(.S_AXIS_TDATA_WIDTH(S), .M_AXIS_TDATA_WIDTH(M)) dut (
    .aclk(aclk), .areset(areset), .cfg_data(cfg_data),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast)
  );

  typedef struct packed {logic last; logic [M-1:0] data;} word_t;

  word_t        exp_q[$];
  word_t        obs_q[$];
  int           n_checks = 0;
  int           n_pass   = 0;
  int           hold_err = 0;
  int           mode     = 0;   // m_axis_tready: 0 always high, 1 toggling, 2 random
  bit           hold_f   = 1'b0;
  logic [M-1:0] hold_d;
  logic         hold_l;

  // Reference: the word list one beat produces under the configuration seen at its start.
  function automatic void model_beat(input logic [S-1:0] d, input logic l, input logic [15:0] c);
    int    n_words;
    int    lane;
    word_t w;
    n_words = int'(c[CW-1:0]) + 1;
    if (n_words > R) n_words = R;
    for (int i = 0; i < n_words; i++) begin
      lane   = c[15] ? (R - 1 - i) : i;
      w.data = d[lane*M +: M];
      w.last = l && (i == n_words - 1);
      exp_q.push_back(w);
    end
  endfunction

  // One clock: sample at the falling edge, then update m_axis_tready after the rising edge.
  task automatic tick(output bit acc);
    @(negedge aclk);
    if (hold_f && !(m_axis_tvalid === 1'b1 && m_axis_tdata === hold_d && m_axis_tlast === hold_l))
      hold_err++;
    hold_f = m_axis_tvalid && !m_axis_tready;
    hold_d = m_axis_tdata;
    hold_l = m_axis_tlast;
    if (m_axis_tvalid && m_axis_tready) obs_q.push_back({m_axis_tlast, m_axis_tdata});
    acc = s_axis_tvalid && s_axis_tready;
    @(posedge aclk);
    #1;
    case (mode)
      1:       m_axis_tready = ~m_axis_tready;
      2:       m_axis_tready = 1'($urandom_range(0, 1));
      default: m_axis_tready = 1'b1;
    endcase
  endtask

  task automatic drain(input int n);
    bit acc;
    s_axis_tvalid = 1'b0;
    for (int i = 0; i < n; i++) tick(acc);
  endtask

  // Present one beat until it is accepted; optionally change cfg or drop valid mid-beat.
  task automatic send_beat(input logic [S-1:0] d, input logic l, input logic [15:0] c,
                           input int change_after, input logic [15:0] c_new,
                           input int gap_prob, input int gap_at, output int ncyc);
    bit acc;
    bit changed;
    int exp_before;
    exp_before = exp_q.size();
    model_beat(d, l, c);
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    cfg_data      = c;
    s_axis_tvalid = 1'b1;
    ncyc    = 0;
    acc     = 1'b0;
    changed = 1'b0;
    while (!acc && ncyc < 200) begin
      tick(acc);
      ncyc++;
      if (!acc) begin
        if (change_after > 0 && !changed && obs_q.size() >= exp_before + change_after) begin
          cfg_data = c_new;
          changed  = 1'b1;
        end
        s_axis_tvalid = !((gap_at > 0 && ncyc >= gap_at && ncyc < gap_at + 3) ||
                          (gap_prob > 0 && $urandom_range(0, 99) < gap_prob));
      end
    end
    s_axis_tvalid = 1'b0;
    n_checks++;
    if (!acc) $display("FAIL beat_accept: beat not accepted after %0d cycles, expected acceptance", ncyc);
    else n_pass++;
  endtask

  task automatic clear_scoreboard();
    obs_q.delete();
    exp_q.delete();
    hold_err = 0;
  endtask

  task automatic test_reset();
    n_checks++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0) $display("FAIL reset_ctrl: valid=%b last=%b, expected 0 0", m_axis_tvalid, m_axis_tlast);
    else n_pass++;
    n_checks++;
    if (m_axis_tdata !== 32'h0) $display("FAIL reset_data: got %h, expected 00000000", m_axis_tdata);
    else n_pass++;
    cfg_data = 16'h0000;
    #1;
    n_checks++;
    if (s_axis_tready !== 1'b1) $display("FAIL reset_ready_cfg0: got %b, expected 1", s_axis_tready);
    else n_pass++;
    cfg_data = 16'h0003;
    #1;
    n_checks++;
    if (s_axis_tready !== 1'b0) $display("FAIL reset_ready_cfg3: got %b, expected 0", s_axis_tready);
    else n_pass++;
  endtask

  task automatic test_lsw_msw();
    int ncyc;
    logic [15:0] cfgs[2];
    cfgs[0] = 16'h0003;
    cfgs[1] = 16'h8003;
    mode = 0;
    m_axis_tready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      clear_scoreboard();
      send_beat(BEAT, 1'b0, cfgs[k], 0, 16'h0, 0, 0, ncyc);
      n_checks++;
      if (ncyc !== 4) $display("FAIL order%0d_ready_cycle: s_ready on cycle %0d, expected 4", k, ncyc);
      else n_pass++;
      drain(4);
      n_checks++;
      if (obs_q.size() < 1 || obs_q[0].data !== (k == 0 ? 32'h11111111 : 32'h44444444))
        $display("FAIL order%0d_first_word: got %0d words / first %h, expected first %h", k, obs_q.size(),
                 obs_q.size() > 0 ? obs_q[0].data : 32'h0, k == 0 ? 32'h11111111 : 32'h44444444);
      else n_pass++;
      n_checks++;
      if (obs_q.size() !== exp_q.size()) $display("FAIL order%0d_count: got %0d words, expected %0d", k, obs_q.size(), exp_q.size());
      else n_pass++;
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) $display("FAIL order%0d_word%0d: got last=%b data=%h, expected last=%b data=%h",
                                            k, i, obs_q[i].last, obs_q[i].data, exp_q[i].last, exp_q[i].data);
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    int ncyc0, ncyc1;
    clear_scoreboard();
    mode = 0;
    send_beat(BEAT, 1'b0, 16'h0001, 0, 16'h0, 0, 0, ncyc0);
    send_beat(~BEAT, 1'b1, 16'h0001, 0, 16'h0, 0, 0, ncyc1);
    drain(4);
    n_checks++;
    if (ncyc0 !== 2 || ncyc1 !== 2) $display("FAIL b2b_ready_cycles: got %0d,%0d, expected 2,2", ncyc0, ncyc1);
    else n_pass++;
    n_checks++;
    if (obs_q.size() !== 4) $display("FAIL b2b_count: got %0d words, expected 4", obs_q.size());
    else n_pass++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL b2b_word%0d: got last=%b data=%h, expected last=%b data=%h",
                                          i, obs_q[i].last, obs_q[i].data, exp_q[i].last, exp_q[i].data);
      else n_pass++;
    end
  endtask

  task automatic test_clamp_cfg_latch();
    int ncyc0, ncyc1;
    clear_scoreboard();
    mode = 0;
    send_beat(BEAT, 1'b1, 16'h0007, 2, 16'h0000, 0, 0, ncyc0);
    send_beat(~BEAT, 1'b1, 16'h0000, 0, 16'h0, 0, 0, ncyc1);
    drain(4);
    n_checks++;
    if (ncyc0 !== 4 || ncyc1 !== 1) $display("FAIL clamp_ready_cycles: got %0d,%0d, expected 4,1", ncyc0, ncyc1);
    else n_pass++;
    n_checks++;
    if (obs_q.size() !== 5) $display("FAIL clamp_count: got %0d words, expected 5", obs_q.size());
    else n_pass++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL clamp_word%0d: got last=%b data=%h, expected last=%b data=%h",
                                          i, obs_q[i].last, obs_q[i].data, exp_q[i].last, exp_q[i].data);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure_gap();
    int ncyc;
    clear_scoreboard();
    mode = 1;
    m_axis_tready = 1'b1;
    send_beat(BEAT, 1'b0, 16'h0003, 0, 16'h0, 0, 2, ncyc);
    send_beat(~BEAT, 1'b1, 16'h8003, 0, 16'h0, 0, 3, ncyc);
    drain(8);
    n_checks++;
    if (hold_err !== 0) $display("FAIL gap_hold: %0d hold violations, expected 0", hold_err);
    else n_pass++;
    n_checks++;
    if (obs_q.size() !== exp_q.size()) $display("FAIL gap_count: got %0d words, expected %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL gap_word%0d: got last=%b data=%h, expected last=%b data=%h",
                                          i, obs_q[i].last, obs_q[i].data, exp_q[i].last, exp_q[i].data);
      else n_pass++;
    end
  endtask

  task automatic test_reset_midbeat();
    bit acc;
    int ncyc;
    clear_scoreboard();
    mode = 0;
    m_axis_tready = 1'b1;
    s_axis_tdata  = BEAT;
    s_axis_tlast  = 1'b0;
    cfg_data      = 16'h0003;
    s_axis_tvalid = 1'b1;
    tick(acc);
    tick(acc);
    #2 areset = 1'b1;
    #1;
    n_checks++;
    if (m_axis_tvalid !== 1'b0) $display("FAIL midreset_valid: got %b, expected 0", m_axis_tvalid);
    else n_pass++;
    @(posedge aclk);
    @(posedge aclk);
    #1 areset = 1'b0;
    hold_f = 1'b0;
    clear_scoreboard();
    send_beat(BEAT, 1'b0, 16'h0003, 0, 16'h0, 0, 0, ncyc);
    drain(4);
    n_checks++;
    if (obs_q.size() < 1 || obs_q[0].data !== 32'h11111111)
      $display("FAIL midreset_restart: got %0d words / first %h, expected first 11111111",
               obs_q.size(), obs_q.size() > 0 ? obs_q[0].data : 32'h0);
    else n_pass++;
    n_checks++;
    if (obs_q.size() !== 4) $display("FAIL midreset_count: got %0d words, expected 4", obs_q.size());
    else n_pass++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL midreset_word%0d: got last=%b data=%h, expected last=%b data=%h",
                                          i, obs_q[i].last, obs_q[i].data, exp_q[i].last, exp_q[i].data);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int          ncyc;
    logic [S-1:0] d;
    clear_scoreboard();
    mode = 2;
    for (int b = 0; b < 60; b++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      send_beat(d, 1'($urandom), 16'($urandom), $urandom_range(0, 2), 16'($urandom), 20, 0, ncyc);
    end
    drain(40);
    n_checks++;
    if (hold_err !== 0) $display("FAIL rand_hold: %0d hold violations, expected 0", hold_err);
    else n_pass++;
    n_checks++;
    if (obs_q.size() !== exp_q.size()) $display("FAIL rand_count: got %0d words, expected %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL rand_word%0d: got last=%b data=%h, expected last=%b data=%h",
                                          i, obs_q[i].last, obs_q[i].data, exp_q[i].last, exp_q[i].data);
      else n_pass++;
    end
  endtask

  initial begin
    areset        = 1'b1;
    cfg_data      = 16'h0000;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;
    test_reset();
    test_lsw_msw();
    test_back_to_back();
    test_clamp_cfg_latch();
    test_backpressure_gap();
    test_reset_midbeat();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
